// File: rtl/alu_decode_stage.sv
// ALU decode stage: decodes a MIPS32 ALU instruction into a one-hot ALU
// control vector, two operands and a destination register, and holds the
// result in a single registered output entry behind a valid/ready handshake.
module alu_decode_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_alu_control,
   output logic [31:0] out_src1,
   output logic [31:0] out_src2,
   output logic [4:0]  out_dest,
   output logic        out_illegal
);

   // Handshake semantics (both sides):
   //   A transfer happens on a rising edge where valid & ready are both 1.
   //   A producer holding valid=1 keeps its data stable until the transfer.
   //   Downstream: out_valid/out_* come straight from the entry register and
   //   stay stable while out_valid=1 and out_ready=0.
   //   Upstream: in_ready = ~out_valid | out_ready, so the entry refills in
   //   the same edge it drains (no bubble). in_ready does not depend on
   //   in_valid, so there is no combinational loop through the upstream.
   //   flush kills the held entry and any same-cycle capture.

   // One-hot ALU control bit positions
   localparam int unsigned C_ADD  = 11;
   localparam int unsigned C_SUB  = 10;
   localparam int unsigned C_SLT  = 9;
   localparam int unsigned C_SLTU = 8;
   localparam int unsigned C_AND  = 7;
   localparam int unsigned C_NOR  = 6;
   localparam int unsigned C_OR   = 5;
   localparam int unsigned C_XOR  = 4;
   localparam int unsigned C_SLL  = 3;
   localparam int unsigned C_SRL  = 2;
   localparam int unsigned C_SRA  = 1;
   localparam int unsigned C_LUI  = 0;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign opcode   = in_inst[31:26];
   assign rt_idx   = in_inst[20:16];
   assign rd_idx   = in_inst[15:11];
   assign shamt    = in_inst[10:6];
   assign funct    = in_inst[5:0];
   assign imm16    = in_inst[15:0];
   assign imm_sext = {{16{imm16[15]}}, imm16};
   assign imm_zext = {16'b0, imm16};

   // The rs index is not needed: its value arrives already read on in_rs_val.
   logic unused_rs_idx;
   assign unused_rs_idx = ^in_inst[25:21];

   // Decoded (next-entry) values
   logic [11:0] dec_ctrl;
   logic [31:0] dec_src1;
   logic [31:0] dec_src2;
   logic [4:0]  dec_dest;
   logic        dec_illegal;
   logic        dec_legal;

   // Combinational decode of the incoming instruction
   always_comb begin
      dec_ctrl    = '0;
      dec_src1    = in_rs_val;
      dec_src2    = in_rt_val;
      dec_dest    = rd_idx;
      dec_legal   = 1'b1;
      dec_illegal = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            dec_dest = rd_idx;
            case (funct)
               FN_ADD, FN_ADDU: dec_ctrl[C_ADD]  = 1'b1;
               FN_SUB, FN_SUBU: dec_ctrl[C_SUB]  = 1'b1;
               FN_SLT:          dec_ctrl[C_SLT]  = 1'b1;
               FN_SLTU:         dec_ctrl[C_SLTU] = 1'b1;
               FN_AND:          dec_ctrl[C_AND]  = 1'b1;
               FN_OR:           dec_ctrl[C_OR]   = 1'b1;
               FN_XOR:          dec_ctrl[C_XOR]  = 1'b1;
               FN_NOR:          dec_ctrl[C_NOR]  = 1'b1;
               // Immediate-shamt shifts carry the shift amount in src1
               FN_SLL: begin
                  dec_ctrl[C_SLL] = 1'b1;
                  dec_src1        = {27'b0, shamt};
               end
               FN_SRL: begin
                  dec_ctrl[C_SRL] = 1'b1;
                  dec_src1        = {27'b0, shamt};
               end
               FN_SRA: begin
                  dec_ctrl[C_SRA] = 1'b1;
                  dec_src1        = {27'b0, shamt};
               end
               // Variable shifts take the amount from rs
               FN_SLLV:         dec_ctrl[C_SLL]  = 1'b1;
               FN_SRLV:         dec_ctrl[C_SRL]  = 1'b1;
               FN_SRAV:         dec_ctrl[C_SRA]  = 1'b1;
               default:         dec_legal        = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec_ctrl[C_ADD] = 1'b1;
            dec_src2        = imm_sext;
            dec_dest        = rt_idx;
         end
         OP_SLTI: begin
            dec_ctrl[C_SLT] = 1'b1;
            dec_src2        = imm_sext;
            dec_dest        = rt_idx;
         end
         OP_SLTIU: begin
            dec_ctrl[C_SLTU] = 1'b1;
            dec_src2         = imm_sext;
            dec_dest         = rt_idx;
         end
         OP_ANDI: begin
            dec_ctrl[C_AND] = 1'b1;
            dec_src2        = imm_zext;
            dec_dest        = rt_idx;
         end
         OP_ORI: begin
            dec_ctrl[C_OR] = 1'b1;
            dec_src2       = imm_zext;
            dec_dest       = rt_idx;
         end
         OP_XORI: begin
            dec_ctrl[C_XOR] = 1'b1;
            dec_src2        = imm_zext;
            dec_dest        = rt_idx;
         end
         OP_LUI: begin
            dec_ctrl[C_LUI] = 1'b1;
            dec_src1        = '0;
            dec_src2        = imm_zext;
            dec_dest        = rt_idx;
         end
         default: dec_legal = 1'b0;
      endcase

      // Unsupported encodings produce an all-zero payload with the flag set
      if (!dec_legal) begin
         dec_ctrl    = '0;
         dec_src1    = '0;
         dec_src2    = '0;
         dec_dest    = '0;
         dec_illegal = 1'b1;
      end
   end

   // Handshake qualifiers
   logic fire_in;
   logic fire_out;

   assign in_ready = ~out_valid | out_ready;
   assign fire_in  = in_valid & in_ready;
   assign fire_out = out_valid & out_ready;

   // Output entry register: flush wins, then capture, then drain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid       <= 1'b0;
         out_alu_control <= '0;
         out_src1        <= '0;
         out_src2        <= '0;
         out_dest        <= '0;
         out_illegal     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (fire_in) begin
         out_valid       <= 1'b1;
         out_alu_control <= dec_ctrl;
         out_src1        <= dec_src1;
         out_src2        <= dec_src2;
         out_dest        <= dec_dest;
         out_illegal     <= dec_illegal;
      end else if (fire_out) begin
         out_valid <= 1'b0;
      end
   end

endmodule
